sum_pulse_counter: RTL and testbench
====================================

Name: sum_pulse_counter

Overview:
- Per-pixel hit counter that consumes the `sumPulse` output of the charge-summing synchronization logic.
- It synchronizes the asynchronous `sumPulse` into the `clk` domain and counts rising edges inside the shutter window.
- On command, it snapshots the count plus an overflow flag into a daisy-chained shift register and serially reads it out to the column periphery.

Parameters:
- CNT_W, 12, counter width in bits; saturation value is 2^CNT_W-1.
- SYNC_STAGES, 2, number of synchronizer flops on `sumPulse`; minimum 2.

Ports:
- clk  input  1  pixel clock
- rst_n  input  1  synchronous active-low reset; sampled on the `clk` rising edge
- sumPulse  input  1  asynchronous hit pulse from the summing/arbitration logic; high for ≥2 `clk` periods
- shutter  input  1  synchronous count enable (frame window)
- readStart  input  1  one-cycle synchronous request to snapshot and shift out
- shiftIn  input  1  serial data from the upstream pixel in the chain
- shiftOut  output  1  serial data to the downstream pixel; overflow bit first, then count MSB first
- readBusy  output  1  high while the shift register holds unread data
- hitStrobe  output  1  one-cycle pulse for each counted hit

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - sync chain, edge flop, counter and ovf cleared.
  - Shift register cleared; state goes to IDLE.
  - shiftOut=0, readBusy=0, hitStrobe=0.
  - Applies mid-readout too; the partial frame is discarded.
- Synchronizer:
  - SYNC_STAGES flops followed by an edge flop.
  - hit = sync_q & ~edge_q, i.e. a rising edge of the synchronized pulse.
  - Latency from a `sumPulse` rise to counter update: SYNC_STAGES+1 edges.
- Counting:
  - A hit with shutter=1 and counting allowed increments the counter by 1 and pulses hitStrobe in the same cycle.
  - At 2^CNT_W-1 the counter holds, ovf sets, and the hit still strobes.
  - ovf is sticky until the next snapshot.
  - A hit with shutter=0 is ignored and does not strobe.
- States: IDLE, SHIFT; bit counter bitCnt of width clog2(CNT_W+1).
- IDLE → SHIFT, when readStart=1 at an edge:
  - sr <= {ovf, counter}, width CNT_W+1.
  - counter and ovf cleared.
  - bitCnt <= CNT_W; readBusy=1.
  - shiftOut = sr MSB (the ovf bit) is valid immediately after that edge.
- SHIFT, each edge:
  - sr <= {sr[CNT_W-1:0], shiftIn}; bitCnt decrements.
  - When bitCnt==0 at an edge: go to IDLE, readBusy=0.
  - readBusy is high for exactly CNT_W+1 cycles.
- readStart while in SHIFT is ignored; no restart and no snapshot.
- In IDLE, shiftOut = sr MSB, which holds the last shifted-in value. The chain is transparent only in SHIFT.
- Snapshot coincident with a hit: the hit belongs to the new frame.
  - Counter becomes 1 (subject to the feature gate below).
  - The snapshot carries the pre-hit value.
- Counter never wraps.

Optional Feature:
- Macro: CONT_RW_EN.
- Defined: continuous read/write. Counting proceeds during SHIFT; a hit in the snapshot cycle yields counter=1.
- Undefined: counting gated off while readBusy=1, and in the snapshot cycle. Such hits are dropped and hitStrobe stays 0; the counter stays 0 until the return to IDLE.

Decomposition:
- Package sum_cnt_pkg:
  - CNT_W default constant.
  - state_t enum {IDLE, SHIFT}.
  - Function for the bit-counter width.
- Sub-module pulse_sync_edge (params SYNC_STAGES; ports clk, rst_n, async_in, rise_out): synchronizer plus rising-edge detector.

Test Plan:
- Reset then 5 `sumPulse` pulses (3 clk high, 3 low) with shutter=1, then readStart → shiftOut sequence 0, 0000_0000_0101; readBusy high 13 cycles; counter=0 afterwards.
- 3 pulses with shutter=0, then readStart → all 13 bits 0; hitStrobe never asserted.
- 4100 pulses with shutter=1 → counter holds 4095, ovf=1; readout gives 1 then twelve 1s; the next frame reads ovf=0.
- shiftIn driven 1,0,1,... during SHIFT → shiftOut presents the local 13 bits, then the shiftIn bits in order. A second readStart mid-shift changes nothing.
- 2 pulses during SHIFT → with CONT_RW_EN the next readout gives count 2; without it, count 0.
- rst_n=0 for 1 cycle at bit 6 of readout → readBusy=0, shiftOut=0 next cycle; a fresh readStart reads count 0.

Source files
------------

// File: rtl/sum_cnt_pkg.sv
// rtl/sum_cnt_pkg.sv - shared constants, state type and sizing helper for the sum pulse counter
package sum_cnt_pkg;

    localparam int DEF_CNT_W = 12;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit counter must be able to hold CNT_W itself, not just CNT_W-1.
    function automatic int bit_cnt_w(input int cnt_w);
        return $clog2(cnt_w + 1);
    endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// rtl/pulse_sync_edge.sv - multi-flop synchronizer with rising-edge detect for an async pulse
module pulse_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_out = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/sum_pulse_counter.sv
// rtl/sum_pulse_counter.sv - per-pixel hit counter with snapshot and daisy-chained serial readout
// Define CONT_RW_EN to keep counting while a readout is shifting out.
module sum_pulse_counter
    import sum_cnt_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sumPulse,
    input  logic shutter,
    input  logic readStart,
    input  logic shiftIn,
    output logic shiftOut,
    output logic readBusy,
    output logic hitStrobe
);

    localparam int BW = bit_cnt_w(CNT_W);

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic             ovf;
    logic [CNT_W:0]   sr;
    logic [BW-1:0]    bit_cnt;
    logic             hit;
    logic             snap;
    logic             count_ok;
    logic             count_en;

    pulse_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (sumPulse),
        .rise_out (hit)
    );

    assign snap = (state == IDLE) && readStart;

    always_comb begin
        count_ok = 1'b1;
`ifdef CONT_RW_EN
        count_ok = 1'b1;
`else
        count_ok = (state == IDLE) && !readStart;
`endif
    end

    assign count_en = hit && shutter && count_ok;

    // A hit landing on the snapshot edge belongs to the new frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            counter   <= '0;
            ovf       <= 1'b0;
            hitStrobe <= 1'b0;
        end else begin
            hitStrobe <= count_en;
            if (snap) begin
                counter <= {{(CNT_W-1){1'b0}}, count_en};
                ovf     <= 1'b0;
            end else if (count_en) begin
                if (counter == {CNT_W{1'b1}})
                    ovf <= 1'b1;
                else
                    counter <= counter + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            sr       <= '0;
            bit_cnt  <= '0;
            readBusy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (readStart) begin
                        sr       <= {ovf, counter};
                        bit_cnt  <= BW'(CNT_W);
                        state    <= SHIFT;
                        readBusy <= 1'b1;
                    end
                end
                SHIFT: begin
                    sr <= {sr[CNT_W-1:0], shiftIn};
                    if (bit_cnt == '0) begin
                        state    <= IDLE;
                        readBusy <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign shiftOut = sr[CNT_W];

endmodule

// File: tb/tb_sum_pulse_counter.sv
// tb/tb_sum_pulse_counter.sv - scoreboard bench for sum_pulse_counter with a hit-count reference model
module tb_sum_pulse_counter;

    localparam int CNT_W = 12;
    localparam int MAXV  = (1 << CNT_W) - 1;
    localparam int FRAME = CNT_W + 1;

    logic clk = 1'b0;
    logic rst_n, sumPulse, shutter, readStart, shiftIn;
    logic shiftOut, readBusy, hitStrobe;

    int checks = 0;
    int errors = 0;

    int        model_hits  = 0;
    int        exp_strobes = 0;
    int        strobe_cnt  = 0;
    bit        abort_pending = 0;
    logic [CNT_W:0] exp_q[$];

    sum_pulse_counter #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sumPulse  (sumPulse),
        .shutter   (shutter),
        .readStart (readStart),
        .shiftIn   (shiftIn),
        .shiftOut  (shiftOut),
        .readBusy  (readBusy),
        .hitStrobe (hitStrobe)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: assembles each readout frame and checks it against the scoreboard.
    initial begin
        logic [CNT_W:0] word;
        logic [CNT_W:0] exp;
        int len;
        word = '0;
        len  = 0;
        forever begin
            @(negedge clk);
            if (hitStrobe) strobe_cnt++;
            if (readBusy) begin
                word = {word[CNT_W-1:0], shiftOut};
                len++;
            end else if (len != 0) begin
                if (abort_pending) begin
                    abort_pending = 0;
                end else begin
                    check("busy_len", len, FRAME);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL readout: unexpected frame %h", word);
                    end else begin
                        exp = exp_q.pop_front();
                        if (word !== exp) begin
                            errors++;
                            $display("FAIL readout: got %h expected %h", word, exp);
                        end
                    end
                end
                len = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input bit sh, input int hi, input int lo);
        shutter  = sh;
        sumPulse = 1'b1;
        tick(hi);
        sumPulse = 1'b0;
        tick(lo);
        if (sh) begin
            model_hits++;
            exp_strobes++;
        end
    endtask

    // Snapshot and shift out; optionally add a mid-shift readStart and two hits during SHIFT.
    task automatic do_read(input bit mid_start, input bit shift_hits);
        logic [FRAME-1:0] bits;
        int v;
        v = (model_hits > MAXV) ? MAXV : model_hits;
        exp_q.push_back({(model_hits > MAXV) ? 1'b1 : 1'b0, v[CNT_W-1:0]});
        model_hits = 0;
        bits = FRAME'($urandom);
        readStart = 1'b1;
        tick(1);
        readStart = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            shiftIn   = bits[k];
            readStart = (mid_start && k == 5);
            if (shift_hits) begin
                shutter  = 1'b1;
                sumPulse = (k == 1 || k == 2 || k == 5 || k == 6);
            end
            tick(1);
        end
        readStart = 1'b0;
        sumPulse  = 1'b0;
        shiftIn   = 1'b0;
`ifdef CONT_RW_EN
        if (shift_hits) begin
            model_hits  += 2;
            exp_strobes += 2;
        end
`endif
        @(negedge clk);
        check("busy_after_read", readBusy, 0);
        check("hold_shiftin", shiftOut, bits[0]);
        tick(6);
        check("strobes", strobe_cnt, exp_strobes);
    endtask

    initial begin
        rst_n = 1'b0; sumPulse = 1'b0; shutter = 1'b0; readStart = 1'b0; shiftIn = 1'b0;
        tick(3);
        @(negedge clk);
        check("rst_busy", readBusy, 0);
        check("rst_shiftout", shiftOut, 0);
        check("rst_strobe", hitStrobe, 0);
        rst_n = 1'b1;
        tick(2);

        for (int i = 0; i < 5; i++) pulse(1'b1, 3, 3);
        tick(6);
        do_read(1'b0, 1'b0);

        for (int i = 0; i < 3; i++) pulse(1'b0, 3, 3);
        tick(6);
        check("no_strobe_shutter_off", strobe_cnt, exp_strobes);
        do_read(1'b0, 1'b0);

        for (int i = 0; i < 4100; i++) pulse(1'b1, 3, 3);
        tick(6);
        do_read(1'b0, 1'b0);
        do_read(1'b0, 1'b0);

        for (int i = 0; i < 7; i++) pulse(1'b1, 2, 3);
        tick(6);
        do_read(1'b1, 1'b0);

        do_read(1'b0, 1'b1);
        do_read(1'b0, 1'b0);

        for (int f = 0; f < 6; f++) begin
            int n;
            n = $urandom_range(0, 25);
            for (int i = 0; i < n; i++)
                pulse(1'($urandom_range(0, 1)), $urandom_range(2, 4), $urandom_range(2, 4));
            shutter = 1'b0;
            tick(6);
            do_read(1'($urandom_range(0, 1)), 1'b0);
        end

        for (int i = 0; i < 4; i++) pulse(1'b1, 3, 3);
        tick(6);
        abort_pending = 1;
        readStart = 1'b1;
        tick(1);
        readStart = 1'b0;
        tick(6);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        model_hits = 0;
        @(negedge clk);
        check("abort_busy", readBusy, 0);
        check("abort_shiftout", shiftOut, 0);
        tick(3);
        do_read(1'b0, 1'b0);

        tick(5);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
